// File: rtl/sram_arbiter_pkg.sv
// Shared types and default parameter values for the SRAM arbiter.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_TURN   = 2'd2
  } state_t;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_ADDR_W     = 20;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ACCESS_CYC = 2;
  localparam int DEF_PRIO0      = 1;

  // Collapse per-byte enables onto the single LB/UB strobe pair (even bytes
  // drive the low lane, odd bytes the high lane). Returns {ub_n, lb_n}.
  function automatic logic [1:0] lane_n(input logic [7:0] be, input int be_w);
    logic lb;
    logic ub;
    lb = |(be & 8'h55);
    ub = (be_w > 1) ? |(be & 8'hAA) : be[0];
    return {~ub, ~lb};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with optional fixed top priority for port 0.
// The search starts at the port after the last granted one; the pointer only
// moves when the caller accepts the grant via advance.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         prio_en,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W:0]   sum;
  logic             found;

  // Pick the first requester, port 0 first when priority is enabled.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    if (prio_en && req[0]) begin
      grant[0] = 1'b1;
      found    = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
        found       = 1'b1;
      end
    end
  end

  // Move the pointer past the port that was just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gidx == IDX_W'(N-1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Multi-port Avalon-MM front end sharing one asynchronous SRAM.
// state  | meaning
// IDLE   | no access in flight, arbitrate every cycle
// ACCESS | SRAM cycle in progress, last cycle accepts and re-arbitrates
// TURN   | one bus-turnaround cycle between a write and a following read
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACCESS_CYC = DEF_ACCESS_CYC,
  parameter int PRIO0      = DEF_PRIO0
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [NUM_PORTS-1:0]          AVL_READ,
  input  logic [NUM_PORTS-1:0]          AVL_WRITE,
  input  logic [NUM_PORTS*ADDR_W-1:0]   AVL_ADDR,
  input  logic [NUM_PORTS*DATA_W/8-1:0] AVL_BYTEEN,
  input  logic [NUM_PORTS*DATA_W-1:0]   AVL_WRITEDATA,
  output logic [NUM_PORTS-1:0]          AVL_WAITREQUEST,
  output logic [DATA_W-1:0]             AVL_READDATA,
  output logic [NUM_PORTS-1:0]          AVL_READDATAVALID,
  output logic [ADDR_W-1:0]             SRAM_ADDR,
  inout  wire  [DATA_W-1:0]             SRAM_DQ,
  output logic                          SRAM_CE_N,
  output logic                          SRAM_OE_N,
  output logic                          SRAM_WE_N,
  output logic                          SRAM_LB_N,
  output logic                          SRAM_UB_N
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYC - 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_PORTS-1:0]   grant_q;
  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   arb_req;
  logic [NUM_PORTS-1:0]   arb_grant;
  logic [NUM_PORTS-1:0]   accept;
  logic [NUM_PORTS-1:0]   rvalid_q;
  logic                   is_wr_q;
  logic                   last_cyc;
  logic                   advance;
  logic                   turn_needed;
  logic [ADDR_W-1:0]      addr_q;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      sel_wdata;
  logic [DATA_W-1:0]      rdata_q;
  logic                   sel_wr;
  logic [1:0]             sel_lanes_n;
  logic [7:0]             be_pad;
  logic                   we_n_q;
  logic                   oe_n_q;
  logic                   lb_n_q;
  logic                   ub_n_q;
  logic                   ce_n_q;
  logic                   dq_oe_q;

  assign req             = AVL_READ | AVL_WRITE;
  assign last_cyc        = (state == ST_ACCESS) && (cnt == '0);
  assign accept          = last_cyc ? grant_q : '0;
  assign AVL_WAITREQUEST = req & ~accept;

  // Eligible requests: everything in IDLE; on the accepting cycle, everyone
  // except the port being accepted (its request is still the old one). After
  // a priority port-0 access we fall back to IDLE so a fresh port-0 request
  // still beats the other ports.
  always_comb begin
    arb_req = '0;
    if (state == ST_IDLE) begin
      arb_req = req;
    end else if (last_cyc && !((PRIO0 == 1) && grant_q[0])) begin
      arb_req = req & ~grant_q;
    end
  end

  assign advance = |arb_grant;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .req     (arb_req),
    .prio_en (PRIO0 == 1),
    .advance (advance),
    .grant   (arb_grant)
  );

  // Select the granted port's command; read+write together counts as a write.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    be_pad    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_grant[i]) begin
        sel_wr               = AVL_WRITE[i];
        sel_addr             = AVL_ADDR[i*ADDR_W +: ADDR_W];
        sel_wdata            = AVL_WRITEDATA[i*DATA_W +: DATA_W];
        be_pad[BE_W-1:0]     = AVL_BYTEEN[i*BE_W +: BE_W];
      end
    end
    sel_lanes_n = sel_wr ? lane_n(be_pad, BE_W) : 2'b00;
    turn_needed = (state == ST_ACCESS) && is_wr_q && !sel_wr;
  end

  // Access sequencer: captures the grant and drives registered SRAM controls.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      grant_q  <= '0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      ce_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
    end else begin
      ce_n_q   <= 1'b0;
      rvalid_q <= '0;
      case (state)
        ST_IDLE, ST_ACCESS: begin
          if (state == ST_ACCESS && cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (state == ST_ACCESS && !is_wr_q) begin
              rdata_q  <= SRAM_DQ;
              rvalid_q <= grant_q;
            end
            if (advance) begin
              grant_q            <= arb_grant;
              is_wr_q            <= sel_wr;
              addr_q             <= sel_addr;
              wdata_q            <= sel_wdata;
              {ub_n_q, lb_n_q}   <= sel_lanes_n;
              cnt                <= CNT_INIT;
              if (turn_needed) begin
                state   <= ST_TURN;
                we_n_q  <= 1'b1;
                oe_n_q  <= 1'b1;
                dq_oe_q <= 1'b0;
              end else begin
                state   <= ST_ACCESS;
                we_n_q  <= ~sel_wr;
                oe_n_q  <= sel_wr;
                dq_oe_q <= sel_wr;
              end
            end else begin
              state   <= ST_IDLE;
              grant_q <= '0;
              we_n_q  <= 1'b1;
              oe_n_q  <= 1'b1;
              lb_n_q  <= 1'b1;
              ub_n_q  <= 1'b1;
              dq_oe_q <= 1'b0;
            end
          end
        end
        ST_TURN: begin
          state  <= ST_ACCESS;
          cnt    <= CNT_INIT;
          oe_n_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign SRAM_DQ           = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign SRAM_ADDR         = addr_q;
  assign SRAM_CE_N         = ce_n_q;
  assign SRAM_OE_N         = oe_n_q;
  assign SRAM_WE_N         = we_n_q;
  assign SRAM_LB_N         = lb_n_q;
  assign SRAM_UB_N         = ub_n_q;
  assign AVL_READDATA      = rdata_q;
  assign AVL_READDATAVALID = rvalid_q;

endmodule
